// File: rtl/serial_sign_mag_converter_if.sv
// Handshake and data bundle for the serial two's-complement to
// sign-magnitude converter. The slave side is the converter itself.
interface serial_sign_mag_converter_if #(
  parameter int unsigned N = 10
);
  logic         start;
  logic [N-1:0] data_in;
  logic         busy;
  logic         done;
  logic         sign;
  logic [N-1:0] mag;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  sign,
    input  mag
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output sign,
    output mag
  );
endinterface

// File: rtl/serial_sign_mag_converter.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One operand bit is processed per clock, LSB first. Negative operands are
// negated with the "copy through the first 1, invert thereafter" rule, so
// no adder is needed. The result is published on the SHIFT->DONE edge and
// held until the next conversion completes.
module serial_sign_mag_converter #(
  parameter int unsigned N = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_sign_mag_converter_if.slave   bus
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [N-1:0]    sh_q,     sh_d;
  logic [N-1:0]    res_q,    res_d;
  logic            found_q,  found_d;
  logic            psign_q,  psign_d;
  logic [N-1:0]    mag_q,    mag_d;
  logic            sign_q,   sign_d;

  logic            in_bit;
  logic            res_bit;

  // Current operand bit and its converted value (inverted only for
  // negative operands once a 1 has already been passed through).
  always_comb begin
    in_bit  = sh_q[0];
    res_bit = in_bit ^ (psign_q & found_q);
  end

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    res_d   = res_q;
    found_d = found_q;
    psign_d = psign_q;
    mag_d   = mag_q;
    sign_d  = sign_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.data_in;
          psign_d = bus.data_in[N-1];
          found_d = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Operand drains from the LSB end; result fills from the MSB end,
        // so after N shifts bit i of the result lands at position i.
        sh_d    = {1'b0, sh_q[N-1:1]};
        res_d   = {res_bit, res_q[N-1:1]};
        found_d = found_q | (psign_q & in_bit);
        if (cnt_q == LAST_BIT) begin
          // Counter is left at its terminal value; IDLE reloads it.
          mag_d   = {res_bit, res_q[N-1:1]};
          sign_d  = psign_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      found_q <= 1'b0;
      psign_q <= 1'b0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      found_q <= found_d;
      psign_q <= psign_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sign = sign_q;
  assign bus.mag  = mag_q;

endmodule

// File: tb/tb_serial_sign_mag_converter.sv
// Directed self-checking bench for serial_sign_mag_converter (N = 10).
module tb_serial_sign_mag_converter;

  localparam int unsigned N = 10;

  logic clk;
  logic rst;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [N-1:0] prev_mag;
  logic         prev_sign;

  serial_sign_mag_converter_if #(.N(N)) bus ();

  serial_sign_mag_converter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;
    #3;
    total_cnt++;
    if ({bus.busy, bus.done, bus.sign, bus.mag} !== {3'b000, 10'd0}) begin
      $display("FAIL reset_outputs: got busy=%b done=%b sign=%b mag=%0d, want all 0",
               bus.busy, bus.done, bus.sign, bus.mag);
    end else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end else pass_cnt++;
    prev_mag  = '0;
    prev_sign = 1'b0;
  endtask

  // One full conversion with busy/done timing and hold checks.
  task automatic run_conv(input string name, input logic [N-1:0] d,
                          input logic exp_sign, input logic [N-1:0] exp_mag);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.data_in = 10'b1010101010;
    for (int i = 1; i <= int'(N); i++) begin
      @(posedge clk);
      #1;
      if (i < int'(N)) begin
        total_cnt++;
        if ({bus.busy, bus.done, bus.sign, bus.mag} !== {2'b10, prev_sign, prev_mag}) begin
          $display("FAIL %s_busy_hold cyc%0d: got busy=%b done=%b sign=%b mag=%0d, want 1 0 %b %0d",
                   name, i, bus.busy, bus.done, bus.sign, bus.mag, prev_sign, prev_mag);
        end else pass_cnt++;
      end else begin
        total_cnt++;
        if ({bus.busy, bus.done, bus.sign, bus.mag} !== {2'b01, exp_sign, exp_mag}) begin
          $display("FAIL %s_result: got busy=%b done=%b sign=%b mag=%0d, want 0 1 %b %0d",
                   name, bus.busy, bus.done, bus.sign, bus.mag, exp_sign, exp_mag);
        end else pass_cnt++;
      end
    end
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.sign, bus.mag} !== {2'b00, exp_sign, exp_mag}) begin
      $display("FAIL %s_after_done: got busy=%b done=%b sign=%b mag=%0d, want 0 0 %b %0d",
               name, bus.busy, bus.done, bus.sign, bus.mag, exp_sign, exp_mag);
    end else pass_cnt++;
    prev_mag  = exp_mag;
    prev_sign = exp_sign;
  endtask

  task automatic test_values();
    run_conv("pos5",    10'b0000000101, 1'b0, 10'd5);
    run_conv("neg5",    10'b1111111011, 1'b1, 10'd5);
    run_conv("neg1",    10'b1111111111, 1'b1, 10'd1);
    run_conv("neg512",  10'b1000000000, 1'b1, 10'd512);
    run_conv("zero",    10'b0000000000, 1'b0, 10'd0);
    run_conv("pos511",  10'b0111111111, 1'b0, 10'd511);
    run_conv("neg511",  10'b1000000001, 1'b1, 10'd511);
    run_conv("neg6",    10'b1111111010, 1'b1, 10'd6);
  endtask

  task automatic test_ignore_start();
    int unsigned done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 10'b0000000101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      if (e == 4) begin
        bus.start   = 1'b1;
        bus.data_in = 10'b1111111101;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
      if (e == 10) begin
        total_cnt++;
        if ({bus.done, bus.sign, bus.mag} !== {2'b10, 10'd5}) begin
          $display("FAIL ignore_start_result: got done=%b sign=%b mag=%0d, want 1 0 5",
                   bus.done, bus.sign, bus.mag);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_seen !== 1) begin
      $display("FAIL ignore_start_done_count: got %0d pulses, want 1", done_seen);
    end else pass_cnt++;
    prev_mag  = 10'd5;
    prev_sign = 1'b0;
  endtask

  task automatic test_reset_abort();
    int unsigned done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 10'b1111111001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.sign, bus.mag} !== {3'b000, 10'd0}) begin
      $display("FAIL abort_outputs: got busy=%b done=%b sign=%b mag=%0d, want all 0",
               bus.busy, bus.done, bus.sign, bus.mag);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) begin
      $display("FAIL abort_no_done: got %0d pulses, want 0", done_seen);
    end else pass_cnt++;
    prev_mag  = '0;
    prev_sign = 1'b0;
    run_conv("after_abort_pos9", 10'b0000001001, 1'b0, 10'd9);
  endtask

  task automatic test_back_to_back();
    logic         exp_busy, exp_done, exp_sign;
    logic [N-1:0] exp_mag;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 10'b0000000001;
    @(posedge clk);
    #1;
    bus.data_in = 10'b1111111110;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      exp_busy = (e <= 9) || (e >= 12 && e <= 21);
      exp_done = (e == 10) || (e == 22);
      if (e < 10) begin
        exp_sign = prev_sign;
        exp_mag  = prev_mag;
      end else if (e < 22) begin
        exp_sign = 1'b0;
        exp_mag  = 10'd1;
      end else begin
        exp_sign = 1'b1;
        exp_mag  = 10'd2;
      end
      total_cnt++;
      if ({bus.busy, bus.done, bus.sign, bus.mag} !== {exp_busy, exp_done, exp_sign, exp_mag}) begin
        $display("FAIL b2b edge%0d: got busy=%b done=%b sign=%b mag=%0d, want %b %b %b %0d",
                 e, bus.busy, bus.done, bus.sign, bus.mag, exp_busy, exp_done, exp_sign, exp_mag);
      end else pass_cnt++;
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      $display("FAIL b2b_idle_after: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end else pass_cnt++;
    prev_mag  = 10'd2;
    prev_sign = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_values();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_sign_mag_converter.md
SERIAL_SIGN_MAG_CONVERTER -- requirements
Module: serial_sign_mag_converter

Interface
REQ-001 SHALL have parameter: N, 10, operand width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to convert data_in, sampled on rising edge of clk.
REQ-005 SHALL have port: data_in  input  N  two's-complement operand, sampled only on the edge that accepts start.
REQ-006 SHALL have port: busy  output  1  high while bits are being processed.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-008 SHALL have port: sign  output  1  sign of last converted operand.
REQ-009 SHALL have port: mag  output  N  unsigned magnitude of last converted operand.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; all registered outputs derive from state and internal registers.
REQ-011 In IDLE with start=1: latch data_in into internal shift register, latch data_in[N-1] as pending sign, clear found_one flag, clear bit counter, go to SHIFT.
REQ-012 In IDLE with start=0: remain in IDLE; outputs hold.
REQ-013 In SHIFT, one operand bit per cycle, LSB first (bit index = counter).
REQ-014 Per-bit rule: if pending sign=0, result bit = input bit; if pending sign=1, result bit = input bit XOR found_one, then found_one |= input bit (copy through first 1, invert thereafter).
REQ-015 Result bits SHALL be assembled in an internal result shift register, filled from MSB side, so after N bits bit i sits at position i.
REQ-016 Counter SHALL be ceil(log2(N))+1 bits minimum; after bit N-1 is processed go to DONE, counter does not wrap into extra shifts.
REQ-017 On SHIFT->DONE edge: mag <= assembled result, sign <= pending sign; mag and sign SHALL not change at any other time except reset.
REQ-018 busy=1 exactly while state=SHIFT; done=1 exactly while state=DONE (one cycle); DONE -> IDLE unconditionally.
REQ-019 Latency: done SHALL rise on the N-th rising edge after the edge that accepted start (N cycles of busy, then one cycle of done).
REQ-020 start asserted in SHIFT or DONE SHALL be ignored (not queued); data_in ignored outside the accepting edge.
REQ-021 Back-to-back: start held high SHALL be accepted in the IDLE cycle after DONE, giving throughput of one conversion per N+2 cycles.
REQ-022 Most negative value (1 followed by N-1 zeros) SHALL yield sign=1, mag=2^(N-1) with no overflow or error indication.
REQ-023 Zero SHALL yield sign=0, mag=0; no negative zero produced.
REQ-024 mag/sign SHALL hold previous result throughout a new conversion until its DONE edge.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, sign=0, mag=0, counter=0, found_one=0, internal registers=0.
REQ-026 rst asserted mid-SHIFT SHALL abort the conversion; no done pulse for the aborted operand; first start after rst release accepted normally.

Verification
REQ-027 N=10, start with data_in=10'b0000000101 (+5) -> busy high 10 cycles, done pulse on 10th edge, sign=0, mag=5.
REQ-028 N=10, data_in=10'b1111111011 (-5) -> sign=1, mag=5; data_in=10'b1111111111 (-1) -> sign=1, mag=1.
REQ-029 N=10, data_in=10'b1000000000 (-512) -> sign=1, mag=512; data_in=0 -> sign=0, mag=0.
REQ-030 Start +5, pulse start with data_in=-3 during cycle 4 of SHIFT -> ignored; result sign=0, mag=5; exactly one done pulse.
REQ-031 Start -7, assert rst at SHIFT cycle 6 -> all outputs 0 immediately, no done; after release, start +9 -> sign=0, mag=9 after 10 cycles.
REQ-032 Hold start=1 with sequence +1, -2 -> two done pulses 12 cycles apart; mag 1 then 2, sign 0 then 1; mag holds 1 during second conversion.
